fft_frame_buffer: RTL and testbench

Upstream framer for the 8-point FFT datapath. It accepts a serial stream of real Q1.15 samples on a valid/ready handshake and packs them into ping-pong frame banks. It presents one complete N-sample frame in parallel, with a frame valid that drives the FFT core's valid_i. Double buffering lets the next frame fill while the current frame is held for the consumer.

---
 rtl/fft_pkg.sv | 27 ++
 rtl/fft_frame_buffer_if.sv | 29 ++
 rtl/fft_window_mul.sv | 16 +
 rtl/fft_frame_buffer.sv | 115 +++++++++++
 tb/tb_fft_frame_buffer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the 8-point FFT datapath: sample format, the Hann
// window table and the Q1.15 round-and-saturate helper.
package fft_pkg;

   localparam int SAMPLE_W = 16;
   localparam int N_FFT    = 8;

   // Periodic 8-point Hann window in Q1.15; 1.0 is clipped to 0x7FFF.
   localparam logic signed [SAMPLE_W-1:0] HANN_WIN [N_FFT] = '{
      16'sh0000, 16'sh12BE, 16'sh4000, 16'sh6D42,
      16'sh7FFF, 16'sh6D42, 16'sh4000, 16'sh12BE
   };

   function automatic logic signed [SAMPLE_W-1:0] q15RoundSat(input logic signed [31:0] prod);
      logic signed [32:0] rounded;
      logic signed [17:0] shifted;
      rounded = 33'(prod) + 33'sd16384;
      shifted = 18'(rounded >>> 15);
      if (shifted > 18'sd32767) begin
         return 16'sh7FFF;
      end else if (shifted < -18'sd32768) begin
         return 16'sh8000;
      end
      return shifted[SAMPLE_W-1:0];
   endfunction

endpackage

// File: rtl/fft_frame_buffer_if.sv
// Sample-stream and frame-delivery signals of the FFT frame buffer.
// The slave modport is the buffer itself, the master modport is its environment.
interface fft_frame_buffer_if
   import fft_pkg::*;
#(
   parameter int N_POINTS   = N_FFT,
   parameter int DATA_WIDTH = SAMPLE_W
);

   logic                         s_valid_i;
   logic                         s_ready_o;
   logic signed [DATA_WIDTH-1:0] s_data_i;
   logic                         flush_i;
   logic                         frame_valid_o;
   logic                         frame_ready_i;
   logic signed [DATA_WIDTH-1:0] frame_o [N_POINTS];
   logic [$clog2(N_POINTS):0]    fill_level_o;

   modport slave (
      input  s_valid_i, s_data_i, flush_i, frame_ready_i,
      output s_ready_o, frame_valid_o, frame_o, fill_level_o
   );

   modport master (
      output s_valid_i, s_data_i, flush_i, frame_ready_i,
      input  s_ready_o, frame_valid_o, frame_o, fill_level_o
   );

endinterface

// File: rtl/fft_window_mul.sv
// Applies one Q1.15 window coefficient to one Q1.15 sample with
// round-half-up and saturation; purely combinational.
module fft_window_mul
   import fft_pkg::*;
(
   input  logic signed [SAMPLE_W-1:0] sample_i,
   input  logic signed [SAMPLE_W-1:0] coef_i,
   output logic signed [SAMPLE_W-1:0] sample_o
);

   logic signed [31:0] product;

   assign product  = 32'(sample_i) * 32'(coef_i);
   assign sample_o = q15RoundSat(product);

endmodule

// File: rtl/fft_frame_buffer.sv
// Ping-pong frame buffer packing a serial sample stream into parallel frames.
// Define FFT_WINDOW_EN to apply the Hann window to each sample before storage.
module fft_frame_buffer
   import fft_pkg::*;
#(
   parameter int N_POINTS   = N_FFT,
   parameter int DATA_WIDTH = SAMPLE_W
)
(
   input logic               clk_i,
   input logic               rst_ni,
   fft_frame_buffer_if.slave bus
);

   localparam int IDX_W  = $clog2(N_POINTS);
   localparam int FILL_W = IDX_W + 1;

   if (N_POINTS < 2 || (N_POINTS & (N_POINTS - 1)) != 0) begin : g_bad_points
      $error("fft_frame_buffer: N_POINTS must be a power of 2 and at least 2");
   end

   logic signed [DATA_WIDTH-1:0] bank_q [2][N_POINTS];
   logic [1:0]                   full_q, full_d;
   logic                         wr_bank_q, wr_bank_d;
   logic                         rd_bank_q, rd_bank_d;
   logic [IDX_W-1:0]             wr_idx_q, wr_idx_d;

   logic                         s_ready;
   logic                         accept;
   logic                         release_frame;
   logic                         last_sample;
   logic signed [DATA_WIDTH-1:0] wr_data;

`ifdef FFT_WINDOW_EN
   if (N_POINTS != N_FFT || DATA_WIDTH != SAMPLE_W) begin : g_bad_window_cfg
      $error("fft_frame_buffer: the Hann window requires N_POINTS == 8 and 16-bit samples");
   end

   logic signed [SAMPLE_W-1:0] win_coef;
   assign win_coef = HANN_WIN[wr_idx_q];

   fft_window_mul u_window_mul (
      .sample_i (bus.s_data_i),
      .coef_i   (win_coef),
      .sample_o (wr_data)
   );
`else
   assign wr_data = bus.s_data_i;
`endif

   assign s_ready       = !full_q[wr_bank_q] && !bus.flush_i;
   assign accept        = bus.s_valid_i && s_ready;
   assign release_frame = full_q[rd_bank_q] && bus.frame_ready_i;
   assign last_sample   = (wr_idx_q == IDX_W'(N_POINTS - 1));

   // Write completion and read release always touch different banks, so both apply together.
   always_comb begin
      full_d    = full_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      wr_idx_d  = wr_idx_q;
      if (release_frame) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = ~rd_bank_q;
      end
      if (bus.flush_i) begin
         wr_idx_d = '0;
      end else if (accept) begin
         if (last_sample) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
            wr_idx_d          = '0;
         end else begin
            wr_idx_d = wr_idx_q + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         full_q    <= '0;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         wr_idx_q  <= '0;
      end else begin
         full_q    <= full_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         wr_idx_q  <= wr_idx_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < N_POINTS; i++) begin
               bank_q[b][i] <= '0;
            end
         end
      end else if (accept) begin
         bank_q[wr_bank_q][wr_idx_q] <= wr_data;
      end
   end

   always_comb begin
      for (int i = 0; i < N_POINTS; i++) begin
         bus.frame_o[i] = bank_q[rd_bank_q][i];
      end
   end

   assign bus.s_ready_o     = s_ready;
   assign bus.frame_valid_o = full_q[rd_bank_q];
   assign bus.fill_level_o  = FILL_W'(wr_idx_q);

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Self-checking bench for fft_frame_buffer: directed vectors, corner-case
// sequences and a randomized run against a queue-based frame model.
module tb_fft_frame_buffer;

   localparam int N  = 8;
   localparam int W  = 16;
   localparam int FW = $clog2(N) + 1;
`ifdef FFT_WINDOW_EN
   localparam bit WIN_ON = 1'b1;
`else
   localparam bit WIN_ON = 1'b0;
`endif
   localparam int HANN [N] = '{0, 4798, 16384, 27970, 32767, 27970, 16384, 4798};

   typedef struct {
      logic          v;
      logic [W-1:0]  d;
      logic          fl;
      logic          fr;
      logic          eValid;
      logic          eReady;
      logic [FW-1:0] eFill;
      logic [N*W-1:0] eFrame;
   } vec_t;

   logic clk  = 1'b0;
   logic rstN = 1'b0;
   always #5 clk = ~clk;

   fft_frame_buffer_if #(.N_POINTS(N), .DATA_WIDTH(W)) bus ();

   fft_frame_buffer #(.N_POINTS(N), .DATA_WIDTH(W)) dut (
      .clk_i  (clk),
      .rst_ni (rstN),
      .bus    (bus)
   );

   int vecCount  = 0;
   int missCount = 0;

   // Reference model: samples of the frame being filled, and completed frames in delivery order.
   logic [W-1:0]   partialQ [$];
   logic [N*W-1:0] frameQ [$];
   logic           lastAccept;

   function automatic logic [W-1:0] winRef(input int idx, input logic [W-1:0] s);
      longint p;
      if (!WIN_ON) return s;
      p = longint'($signed(s)) * longint'(HANN[idx]);
      p = (p + 16384) >>> 15;
      if (p > 32767) p = 32767;
      else if (p < -32768) p = -32768;
      return W'(p);
   endfunction

   function automatic logic [N*W-1:0] packSeq(input int base);
      logic [N*W-1:0] f;
      for (int i = 0; i < N; i++) f[i*W +: W] = winRef(i, W'(base + i));
      return f;
   endfunction

   function automatic logic [N*W-1:0] actFrame();
      logic [N*W-1:0] f;
      for (int i = 0; i < N; i++) f[i*W +: W] = bus.frame_o[i];
      return f;
   endfunction

   task automatic compare(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic fl, input logic fr);
      bus.s_valid_i     = v;
      bus.s_data_i      = d;
      bus.flush_i       = fl;
      bus.frame_ready_i = fr;
      #1;
   endtask

   task automatic checkOutput();
      logic expValid, expReady;
      expValid = (frameQ.size() > 0);
      expReady = (frameQ.size() < 2) && !bus.flush_i;
      compare("model_frame_valid", bus.frame_valid_o, expValid);
      compare("model_s_ready", bus.s_ready_o, expReady);
      compare("model_fill_level", bus.fill_level_o, FW'(partialQ.size()));
      if (expValid) compare("model_frame", actFrame(), frameQ[0]);
   endtask

   task automatic advance();
      logic acc, rel;
      logic [N*W-1:0] f;
      acc = bus.s_valid_i && (frameQ.size() < 2) && !bus.flush_i;
      rel = (frameQ.size() > 0) && bus.frame_ready_i;
      if (rel) void'(frameQ.pop_front());
      if (bus.flush_i) begin
         partialQ.delete();
      end else if (acc) begin
         partialQ.push_back(winRef(partialQ.size(), bus.s_data_i));
         if (partialQ.size() == N) begin
            for (int i = 0; i < N; i++) f[i*W +: W] = partialQ[i];
            frameQ.push_back(f);
            partialQ.delete();
         end
      end
      lastAccept = acc;
      @(negedge clk);
   endtask

   task automatic cycle(input logic v, input logic [W-1:0] d, input logic fl, input logic fr);
      applyStimulus(v, d, fl, fr);
      checkOutput();
      advance();
   endtask

   task automatic doReset();
      rstN = 1'b0;
      #1;
      compare("reset_frame_valid", bus.frame_valid_o, 1'b0);
      compare("reset_fill_level", bus.fill_level_o, '0);
      compare("reset_frame_zero", actFrame(), '0);
      partialQ.delete();
      frameQ.delete();
      bus.s_valid_i     = 1'b0;
      bus.flush_i       = 1'b0;
      bus.frame_ready_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rstN = 1'b1;
      #1;
      compare("reset_s_ready", bus.s_ready_o, 1'b1);
      @(negedge clk);
   endtask

   vec_t tbl [10];

   initial begin
      int sent;
      int budget;
      logic [N*W-1:0] winPos, winNeg;

      for (int i = 0; i < N; i++) begin
         tbl[i] = '{v: 1'b1, d: W'(i + 1), fl: 1'b0, fr: 1'b1, eValid: 1'b0,
                    eReady: 1'b1, eFill: FW'(i), eFrame: '0};
      end
      tbl[8] = '{v: 1'b0, d: '0, fl: 1'b0, fr: 1'b1, eValid: 1'b1, eReady: 1'b1,
                 eFill: '0, eFrame: packSeq(1)};
      tbl[9] = '{v: 1'b0, d: '0, fl: 1'b0, fr: 1'b1, eValid: 1'b0, eReady: 1'b1,
                 eFill: '0, eFrame: '0};

      bus.s_valid_i     = 1'b0;
      bus.s_data_i      = '0;
      bus.flush_i       = 1'b0;
      bus.frame_ready_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      doReset();

      // Back-to-back frame with an always-ready consumer.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(tbl[i].v, tbl[i].d, tbl[i].fl, tbl[i].fr);
         compare($sformatf("tbl%0d_frame_valid", i), bus.frame_valid_o, tbl[i].eValid);
         compare($sformatf("tbl%0d_s_ready", i), bus.s_ready_o, tbl[i].eReady);
         compare($sformatf("tbl%0d_fill", i), bus.fill_level_o, tbl[i].eFill);
         if (tbl[i].eValid) compare($sformatf("tbl%0d_frame", i), actFrame(), tbl[i].eFrame);
         checkOutput();
         advance();
      end

      // Consumer stalled: both banks fill and the stream backs up.
      sent = 0;
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, W'(sent + 1), 1'b0, 1'b0);
         if (lastAccept) sent++;
      end
      compare("stall_accept_count", sent, 16);
      applyStimulus(1'b1, W'(sent + 1), 1'b0, 1'b1);
      compare("stall_s_ready", bus.s_ready_o, 1'b0);
      compare("stall_first_frame", actFrame(), packSeq(1));
      checkOutput();
      advance();
      if (lastAccept) sent++;
      budget = 0;
      while (sent < 20 && budget < 40) begin
         cycle(1'b1, W'(sent + 1), 1'b0, 1'b1);
         if (lastAccept) sent++;
         budget++;
      end
      compare("stall_tail_accepted", sent, 20);
      budget = 0;
      while (frameQ.size() > 0 && budget < 40) begin
         cycle(1'b0, '0, 1'b0, 1'b1);
         budget++;
      end
      compare("stall_drained", frameQ.size(), 0);

      // Flush discards a partial frame.
      cycle(1'b0, '0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b1, W'(16'h0050 + i), 1'b0, 1'b1);
      applyStimulus(1'b1, 16'h0099, 1'b1, 1'b1);
      compare("flush_fill_level", bus.fill_level_o, FW'(3));
      compare("flush_s_ready", bus.s_ready_o, 1'b0);
      checkOutput();
      advance();
      applyStimulus(1'b1, 16'h0100, 1'b0, 1'b0);
      compare("post_flush_fill", bus.fill_level_o, '0);
      checkOutput();
      advance();
      for (int i = 1; i < N; i++) cycle(1'b1, W'(16'h0100 + i), 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      compare("flush_frame_valid", bus.frame_valid_o, 1'b1);
      compare("flush_frame", actFrame(), packSeq(16'h0100));
      checkOutput();
      advance();
      cycle(1'b0, '0, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b1);

      // Reset with one full bank and five pending samples.
      for (int i = 0; i < N + 5; i++) cycle(1'b1, W'(16'h0300 + i), 1'b0, 1'b0);
      doReset();
      for (int i = 0; i < N; i++) cycle(1'b1, W'(16'h0200 + i), 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      compare("after_reset_frame", actFrame(), packSeq(16'h0200));
      checkOutput();
      advance();
      cycle(1'b0, '0, 1'b0, 1'b1);

`ifdef FFT_WINDOW_EN
      winPos = {16'h12BE, 16'h4000, 16'h6D41, 16'h7FFE, 16'h6D41, 16'h4000, 16'h12BE, 16'h0000};
      winNeg = {16'hED42, 16'hC000, 16'h92BE, 16'h8001, 16'h92BE, 16'hC000, 16'hED42, 16'h0000};
      for (int i = 0; i < N; i++) cycle(1'b1, 16'h7FFF, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      compare("window_pos_full_scale", actFrame(), winPos);
      checkOutput();
      advance();
      cycle(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < N; i++) cycle(1'b1, 16'h8000, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      compare("window_neg_full_scale", actFrame(), winNeg);
      checkOutput();
      advance();
      cycle(1'b0, '0, 1'b0, 1'b1);
`else
      winPos = '0;
      winNeg = '0;
`endif

      // Randomized traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         if (i == 750) doReset();
         cycle($urandom_range(0, 99) < 70, W'($urandom), $urandom_range(0, 99) < 3,
               $urandom_range(0, 99) < 50);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
